// File: rtl/mem_block_master_pkg.sv
// Shared constants for the memory block master: bus/count widths, op codes and FSM states.
package mem_block_master_pkg;

  localparam int unsigned MBM_DATAWIDTH_BUS   = 32;
  localparam int unsigned MBM_DATAWIDTH_COUNT = 16;
  localparam int unsigned MBM_ADDR_STEP       = 4;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_WR_REQ = 3'd2,
    ST_NEXT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_block_master_addrgen.sv
// Source/destination address registers with step adders and the remaining-word down-counter.
module mem_block_master_addrgen
  import mem_block_master_pkg::*;
#(
  parameter int unsigned AW   = MBM_DATAWIDTH_BUS,
  parameter int unsigned CW   = MBM_DATAWIDTH_COUNT,
  parameter int unsigned STEP = MBM_ADDR_STEP
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          advance_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [CW-1:0] count_i,
  output logic [AW-1:0] src_o,
  output logic [AW-1:0] dst_o,
  output logic          zero_o
);

  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zero_q;

  // Addresses wrap silently modulo 2^AW.
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      cnt_d = count_i;
    end else if (advance_i) begin
      src_d = src_q + AW'(STEP);
      dst_d = dst_q + AW'(STEP);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign src_o  = src_q;
  assign dst_o  = dst_q;
  assign zero_o = zero_q;

endmodule

// File: rtl/mem_block_master.sv
// Block fill/copy bus initiator on the RD/WRMAIN/ACK memory port.
// Optional ACK timeout is built when MEM_BLOCK_MASTER_TIMEOUT_EN is defined.
module mem_block_master
  import mem_block_master_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS   = MBM_DATAWIDTH_BUS,
  parameter int unsigned DATAWIDTH_COUNT = MBM_DATAWIDTH_COUNT,
  parameter int unsigned ADDR_STEP       = MBM_ADDR_STEP
`ifdef MEM_BLOCK_MASTER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                       MEM_BLOCK_MASTER_CLOCK_50,
  input  logic                       MEM_BLOCK_MASTER_ResetInHigh_In,
  input  logic                       MEM_BLOCK_MASTER_Start_In,
  input  logic                       MEM_BLOCK_MASTER_Op_In,
  input  logic [DATAWIDTH_BUS-1:0]   MEM_BLOCK_MASTER_SrcAddr_InBus,
  input  logic [DATAWIDTH_BUS-1:0]   MEM_BLOCK_MASTER_DstAddr_InBus,
  input  logic [DATAWIDTH_COUNT-1:0] MEM_BLOCK_MASTER_Count_InBus,
  input  logic [DATAWIDTH_BUS-1:0]   MEM_BLOCK_MASTER_Pattern_InBus,
  input  logic                       MEM_BLOCK_MASTER_ACK_In,
  input  logic [DATAWIDTH_BUS-1:0]   MEM_BLOCK_MASTER_MemoryData_InBus,
  output logic [DATAWIDTH_BUS-1:0]   MEM_BLOCK_MASTER_A_OutBus,
  output logic [DATAWIDTH_BUS-1:0]   MEM_BLOCK_MASTER_B_OutBus,
  output logic                       MEM_BLOCK_MASTER_RD_Out,
  output logic                       MEM_BLOCK_MASTER_WRMain_Out,
  output logic                       MEM_BLOCK_MASTER_Busy_Out,
  output logic                       MEM_BLOCK_MASTER_Done_Out,
  output logic                       MEM_BLOCK_MASTER_Error_Out
);

  localparam int unsigned W = DATAWIDTH_BUS;

  logic clk, rst;
  assign clk = MEM_BLOCK_MASTER_CLOCK_50;
  assign rst = MEM_BLOCK_MASTER_ResetInHigh_In;

  state_e         state_q, state_d;
  logic           op_q;
  logic [W-1:0]   pat_q;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           rd_q, rd_d, wr_q, wr_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic           accept, rd_ack, wr_ack, timeout;
  logic           op_eff;
  logic [W-1:0]   pat_eff, src_cur, dst_cur;
  logic           cnt_zero;

  assign accept  = (state_q == ST_IDLE) && MEM_BLOCK_MASTER_Start_In;
  assign rd_ack  = (state_q == ST_RD_REQ) && MEM_BLOCK_MASTER_ACK_In;
  assign wr_ack  = (state_q == ST_WR_REQ) && MEM_BLOCK_MASTER_ACK_In;
  assign op_eff  = accept ? MEM_BLOCK_MASTER_Op_In : op_q;
  assign pat_eff = accept ? MEM_BLOCK_MASTER_Pattern_InBus : pat_q;

  // Addresses advance on the write acknowledge so NEXT already sees the new count.
  mem_block_master_addrgen #(
    .AW   (DATAWIDTH_BUS),
    .CW   (DATAWIDTH_COUNT),
    .STEP (ADDR_STEP)
  ) u_addrgen (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (accept),
    .advance_i (wr_ack),
    .src_i     (MEM_BLOCK_MASTER_SrcAddr_InBus),
    .dst_i     (MEM_BLOCK_MASTER_DstAddr_InBus),
    .count_i   (MEM_BLOCK_MASTER_Count_InBus),
    .src_o     (src_cur),
    .dst_o     (dst_cur),
    .zero_o    (cnt_zero)
  );

`ifdef MEM_BLOCK_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_q;
  logic          in_req;

  assign in_req  = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign timeout = in_req && !MEM_BLOCK_MASTER_ACK_In && (wait_q == TW'(TIMEOUT_CYCLES - 1));

  // Counts request cycles without ACK; zero outside a waiting request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else if (in_req && !MEM_BLOCK_MASTER_ACK_In && !timeout) begin
      wait_q <= wait_q + TW'(1);
    end else begin
      wait_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (MEM_BLOCK_MASTER_Start_In) begin
          if (MEM_BLOCK_MASTER_Count_InBus == '0) state_d = ST_DONE;
          else state_d = (MEM_BLOCK_MASTER_Op_In == OP_COPY) ? ST_RD_REQ : ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        if (MEM_BLOCK_MASTER_ACK_In) state_d = ST_WR_REQ;
        else if (timeout)            state_d = ST_DONE;
      end
      ST_WR_REQ: begin
        if (MEM_BLOCK_MASTER_ACK_In) state_d = ST_NEXT;
        else if (timeout)            state_d = ST_DONE;
      end
      ST_NEXT: begin
        if (cnt_zero) state_d = ST_DONE;
        else state_d = (op_q == OP_COPY) ? ST_RD_REQ : ST_WR_REQ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; A/B change only when a new request begins.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    busy_d = busy_q;
    err_d  = err_q;
    done_d = (state_q == ST_DONE);
    rd_d   = (state_d == ST_RD_REQ);
    wr_d   = (state_d == ST_WR_REQ);
    if (accept) begin
      busy_d = 1'b1;
      err_d  = 1'b0;
    end
    if (state_q == ST_DONE) busy_d = 1'b0;
    if (timeout)            err_d  = 1'b1;
    if (state_d != state_q) begin
      if (state_d == ST_RD_REQ) begin
        a_d = accept ? MEM_BLOCK_MASTER_SrcAddr_InBus : src_cur;
      end else if (state_d == ST_WR_REQ) begin
        a_d = accept ? MEM_BLOCK_MASTER_DstAddr_InBus : dst_cur;
        b_d = (op_eff == OP_FILL) ? pat_eff :
              (rd_ack ? MEM_BLOCK_MASTER_MemoryData_InBus : b_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_FILL;
      pat_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= MEM_BLOCK_MASTER_Op_In;
        pat_q <= MEM_BLOCK_MASTER_Pattern_InBus;
      end
      a_q    <= a_d;
      b_q    <= b_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign MEM_BLOCK_MASTER_A_OutBus   = a_q;
  assign MEM_BLOCK_MASTER_B_OutBus   = b_q;
  assign MEM_BLOCK_MASTER_RD_Out     = rd_q;
  assign MEM_BLOCK_MASTER_WRMain_Out = wr_q;
  assign MEM_BLOCK_MASTER_Busy_Out   = busy_q;
  assign MEM_BLOCK_MASTER_Done_Out   = done_q;
  assign MEM_BLOCK_MASTER_Error_Out  = err_q;

endmodule

// File: tb/tb_mem_block_master.sv
// Self-checking bench for mem_block_master: memory responder, transaction log and reference model.
module tb_mem_block_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] src = '0, dst = '0, pat = '0, mdata = '0;
  logic [15:0] cnt = '0;
  logic        ack = 1'b0;
  logic [31:0] a, b;
  logic        rd, wr, busy, done, err;

  always #5 clk = ~clk;

`ifdef MEM_BLOCK_MASTER_TIMEOUT_EN
  mem_block_master #(.TIMEOUT_CYCLES(8)) dut (
    .MEM_BLOCK_MASTER_CLOCK_50         (clk),
    .MEM_BLOCK_MASTER_ResetInHigh_In   (rst),
    .MEM_BLOCK_MASTER_Start_In         (start),
    .MEM_BLOCK_MASTER_Op_In            (op),
    .MEM_BLOCK_MASTER_SrcAddr_InBus    (src),
    .MEM_BLOCK_MASTER_DstAddr_InBus    (dst),
    .MEM_BLOCK_MASTER_Count_InBus      (cnt),
    .MEM_BLOCK_MASTER_Pattern_InBus    (pat),
    .MEM_BLOCK_MASTER_ACK_In           (ack),
    .MEM_BLOCK_MASTER_MemoryData_InBus (mdata),
    .MEM_BLOCK_MASTER_A_OutBus         (a),
    .MEM_BLOCK_MASTER_B_OutBus         (b),
    .MEM_BLOCK_MASTER_RD_Out           (rd),
    .MEM_BLOCK_MASTER_WRMain_Out       (wr),
    .MEM_BLOCK_MASTER_Busy_Out         (busy),
    .MEM_BLOCK_MASTER_Done_Out         (done),
    .MEM_BLOCK_MASTER_Error_Out        (err)
  );
`else
  mem_block_master dut (
    .MEM_BLOCK_MASTER_CLOCK_50         (clk),
    .MEM_BLOCK_MASTER_ResetInHigh_In   (rst),
    .MEM_BLOCK_MASTER_Start_In         (start),
    .MEM_BLOCK_MASTER_Op_In            (op),
    .MEM_BLOCK_MASTER_SrcAddr_InBus    (src),
    .MEM_BLOCK_MASTER_DstAddr_InBus    (dst),
    .MEM_BLOCK_MASTER_Count_InBus      (cnt),
    .MEM_BLOCK_MASTER_Pattern_InBus    (pat),
    .MEM_BLOCK_MASTER_ACK_In           (ack),
    .MEM_BLOCK_MASTER_MemoryData_InBus (mdata),
    .MEM_BLOCK_MASTER_A_OutBus         (a),
    .MEM_BLOCK_MASTER_B_OutBus         (b),
    .MEM_BLOCK_MASTER_RD_Out           (rd),
    .MEM_BLOCK_MASTER_WRMain_Out       (wr),
    .MEM_BLOCK_MASTER_Busy_Out         (busy),
    .MEM_BLOCK_MASTER_Done_Out         (done),
    .MEM_BLOCK_MASTER_Error_Out        (err)
  );
`endif

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] dut_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int ack_limit = 1 << 30;
  int acks_given = 0;
  int max_lat = 0;
  int lat_cnt = 0;
  bit fixed_lat = 1'b0;
  bit stray_en = 1'b0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int busy_cycles = 0;

  function automatic logic [31:0] init_val(input logic [31:0] ad);
    return {ad[15:0], ~ad[15:0]} ^ 32'h5A5A_1234;
  endfunction

  // Memory responder: acks a strobe after a latency, logs every accepted transfer.
  initial begin
    forever begin
      @(negedge clk);
      ack = 1'b0;
      if ((rd || wr) && acks_given < ack_limit) begin
        if (lat_cnt == 0) begin
          ack = 1'b1;
          acks_given++;
          if (rd) begin
            mdata = dut_mem.exists(a) ? dut_mem[a] : init_val(a);
            log_q.push_back(txn_t'{1'b0, a, mdata});
          end else begin
            dut_mem[a] = b;
            log_q.push_back(txn_t'{1'b1, a, b});
          end
          lat_cnt = fixed_lat ? max_lat : int'($urandom_range(32'(max_lat), 0));
        end else begin
          lat_cnt--;
        end
      end else if (!(rd || wr) && stray_en) begin
        ack = 1'($urandom_range(1, 0));
      end
    end
  end

  always @(negedge clk) begin
    if (rd && wr) overlap_cnt++;
    if (done)     done_cnt++;
    if (busy)     busy_cycles++;
  end

  // Reference: ascending word order, each copied word read before it is written.
  task automatic build_expected(input logic o, input logic [31:0] s, input logic [31:0] d,
                                input logic [15:0] n, input logic [31:0] p);
    logic [31:0] sa, da, v;
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      sa = s + 32'(i * 4);
      da = d + 32'(i * 4);
      if (o) begin
        v = ref_mem.exists(sa) ? ref_mem[sa] : init_val(sa);
        exp_q.push_back(txn_t'{1'b0, sa, v});
      end else begin
        v = p;
      end
      ref_mem[da] = v;
      exp_q.push_back(txn_t'{1'b1, da, v});
    end
  endtask

  task automatic clear_mem();
    dut_mem.delete();
    ref_mem.delete();
  endtask

  task automatic run_xfer(input string name, input logic o, input logic [31:0] s,
                          input logic [31:0] d, input logic [15:0] n, input logic [31:0] p,
                          input int lat, input bit fixed, input bit noise);
    int  budget, done_at, busy_exp, nchk;
    bit  seen;
    build_expected(o, s, d, n, p);
    log_q.delete();
    max_lat = lat; fixed_lat = fixed; lat_cnt = lat;
    acks_given = 0; ack_limit = 1 << 30;
    @(negedge clk);
    op = o; src = s; dst = d; cnt = n; pat = p; start = 1'b1;
    done_cnt = 0; overlap_cnt = 0; busy_cycles = 0;
    stray_en = noise;
    budget = 20 + int'(n) * (2 * lat + 6);
    seen = 1'b0; done_at = 0;
    for (int c = 1; c <= budget && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1; done_at = c;
      end else if (noise) begin
        start = 1'($urandom_range(1, 0));
        op = 1'($urandom_range(1, 0));
        src = $urandom; dst = $urandom; cnt = 16'($urandom); pat = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0; stray_en = 1'b0;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s done_wait: no Done within %0d cycles", name, budget);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (log_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL %s txn_count: got %0d expected %0d", name, log_q.size(), exp_q.size());
    end
    nchk = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < nchk; i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s txn[%0d]: got wr=%0b a=%h d=%h expected wr=%0b a=%h d=%h", name, i,
                 log_q[i].wr, log_q[i].addr, log_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (overlap_cnt !== 0) begin
      errors++; $display("FAIL %s rd_wr_overlap: got %0d cycles expected 0", name, overlap_cnt);
    end
    checks++;
    if ({busy, err, rd, wr} !== 4'b0000) begin
      errors++; $display("FAIL %s idle_flags: got busy/err/rd/wr=%b expected 0000", name, {busy, err, rd, wr});
    end
    if (lat == 0 && fixed) begin
      busy_exp = (n == 16'd0) ? 1 : (o ? 3 : 2) * int'(n) + 1;
      checks++;
      if (busy_cycles !== busy_exp) begin
        errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, busy_exp);
      end
      checks++;
      if (done_at !== busy_exp + 1) begin
        errors++; $display("FAIL %s done_latency: got %0d expected %0d", name, done_at, busy_exp + 1);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({a, b, rd, wr, busy, done, err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got a=%h b=%h flags=%b expected all 0", a, b, {rd, wr, busy, done, err});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a, b, rd, wr, busy, done, err} !== '0) begin
      errors++; $display("FAIL post_reset_idle: got a=%h b=%h flags=%b expected all 0", a, b, {rd, wr, busy, done, err});
    end
  endtask

  task automatic test_fill();
    clear_mem();
    run_xfer("fill_basic", 1'b0, 32'h0, 32'h100, 16'd3, 32'hDEAD_BEEF, 1, 1'b1, 1'b0);
    checks++;
    if (log_q.size() != 3 || log_q[2] !== txn_t'{1'b1, 32'h108, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL fill_last_write: got %0d txns, expected third write 0x108=DEADBEEF", log_q.size());
    end
    clear_mem();
    run_xfer("fill_zero_wait", 1'b0, 32'h0, 32'h2000, 16'd5, 32'h0BAD_F00D, 0, 1'b1, 1'b0);
  endtask

  task automatic test_copy();
    clear_mem();
    dut_mem[32'h0] = 32'h1111_1111; ref_mem[32'h0] = 32'h1111_1111;
    dut_mem[32'h4] = 32'h2222_2222; ref_mem[32'h4] = 32'h2222_2222;
    run_xfer("copy_basic", 1'b1, 32'h0, 32'h40, 16'd2, 32'h0, 0, 1'b1, 1'b0);
    checks++;
    if (log_q.size() != 4 || log_q[3] !== txn_t'{1'b1, 32'h44, 32'h2222_2222}) begin
      errors++; $display("FAIL copy_second_write: got %0d txns, expected write 0x44=22222222 last", log_q.size());
    end
    clear_mem();
    run_xfer("copy_overlap", 1'b1, 32'h200, 32'h204, 16'd4, 32'h0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_count_zero();
    clear_mem();
    run_xfer("count_zero", 1'b1, 32'h10, 32'h20, 16'd0, 32'h1234_5678, 0, 1'b1, 1'b0);
  endtask

  task automatic test_ignore();
    clear_mem();
    run_xfer("ignore_fill", 1'b0, 32'h0, 32'h300, 16'd4, 32'hCAFE_0001, 1, 1'b0, 1'b1);
    clear_mem();
    run_xfer("ignore_copy", 1'b1, 32'h400, 32'h800, 16'd3, 32'h0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    clear_mem();
    run_xfer("wrap_fill", 1'b0, 32'h0, 32'hFFFF_FFFC, 16'd2, 32'hA5A5_5A5A, 0, 1'b1, 1'b0);
    checks++;
    if (log_q.size() != 2 || log_q[1].addr !== 32'h0) begin
      errors++; $display("FAIL wrap_addr: got %0d txns, expected second write to 00000000", log_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    clear_mem();
    log_q.delete();
    max_lat = 0; fixed_lat = 1'b1; lat_cnt = 0; acks_given = 0; ack_limit = 1;
    @(negedge clk);
    op = 1'b0; dst = 32'hFFFF_FFFC; cnt = 16'd2; pat = 32'h7777_8888; start = 1'b1;
    done_cnt = 0;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr && a == 32'h0) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL rstmid_second_wr: second write to 00000000 not seen");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a, b, rd, wr, busy, done, err} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got a=%h b=%h flags=%b expected all 0", a, b, {rd, wr, busy, done, err});
    end
    rst = 1'b0;
    ack_limit = 1 << 30;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || log_q.size() !== 1) begin
      errors++; $display("FAIL rstmid_abandon: got done=%0d txns=%0d expected 0 and 1", done_cnt, log_q.size());
    end
  endtask

  task automatic test_random();
    logic        o;
    logic [31:0] s, d, p;
    logic [15:0] n;
    for (int t = 0; t < 6; t++) begin
      o = 1'($urandom_range(1, 0));
      s = {$urandom_range(32'hFFFF, 0), 16'h0} | (32'($urandom_range(63, 0)) << 2);
      d = {$urandom_range(32'hFFFF, 0), 16'h0} | (32'($urandom_range(63, 0)) << 2);
      n = 16'($urandom_range(8, 1));
      p = $urandom;
      clear_mem();
      run_xfer("random", o, s, d, n, p, int'($urandom_range(3, 0)), 1'b0, 1'($urandom_range(1, 0)));
    end
  endtask

`ifdef MEM_BLOCK_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int  wr_cycles;
    bit  seen, dropped;
    clear_mem();
    log_q.delete();
    ack_limit = 0; acks_given = 0;
    @(negedge clk);
    op = 1'b0; dst = 32'h80; cnt = 16'd3; pat = 32'h1; start = 1'b1;
    done_cnt = 0;
    wr_cycles = 0; dropped = 1'b0;
    for (int c = 0; c < 40 && !dropped; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr) wr_cycles++;
      else if (wr_cycles > 0) dropped = 1'b1;
    end
    checks++;
    if (wr_cycles !== 8) begin
      errors++; $display("FAIL timeout_wr_len: got %0d cycles expected 8", wr_cycles);
    end
    seen = done;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    checks++;
    if (!seen || err !== 1'b1) begin
      errors++; $display("FAIL timeout_done_err: got done=%0b err=%0b expected 1 and 1", seen, err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || done_cnt !== 1) begin
      errors++; $display("FAIL timeout_sticky: got err=%0b done=%0d expected 1 and 1", err, done_cnt);
    end
    ack_limit = 1 << 30;
    clear_mem();
    run_xfer("timeout_clear", 1'b0, 32'h0, 32'h90, 16'd1, 32'h2, 0, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_count_zero();
    test_ignore();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef MEM_BLOCK_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
